render_result_banner: RTL and testbench

Parametrised end-of-game result overlay renderer: a full-width banner with a scaled headline bitmap (WIN or LOSE glyph ROM) and a scaled blinking sub-line ("tap to continue"). Unlike the fixed win/lose renderer, position, size and scale are parameters, glyph ROMs are external ports, and the banner runs a frame-synchronous animation: grow-in, then hold, then blink. It sits in the VGA pixel path beside the other scene renderers; the top-level mux selects its pixel output in the WIN/LOSE scenes.

---
 rtl/render_result_banner_if.sv | 28 ++
 rtl/render_result_banner.sv | 200 ++++++++++++++++++++
 tb/tb_render_result_banner.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/render_result_banner_if.sv
// Pixel-path bundle between the scan generator / glyph ROMs (master) and the
// result banner renderer (slave).
interface render_result_banner_if;
  // start, clear and frame_tick are single-cycle pulses with no back-pressure;
  // ready is a level that stays high while the banner is in its blink phase.
  logic [9:0]  h_cnt;
  logic [9:0]  v_cnt;
  logic        frame_tick;
  logic        start;
  logic        win;
  logic        clear;
  logic [10:0] head_addr;
  logic        head_bit;
  logic [10:0] sub_addr;
  logic        sub_bit;
  logic [11:0] pixel;
  logic        ready;

  modport master (
    output h_cnt, v_cnt, frame_tick, start, win, clear, head_bit, sub_bit,
    input  head_addr, sub_addr, pixel, ready
  );

  modport slave (
    input  h_cnt, v_cnt, frame_tick, start, win, clear, head_bit, sub_bit,
    output head_addr, sub_addr, pixel, ready
  );
endinterface

// File: rtl/render_result_banner.sv
// End-of-game result banner: grows in from the centre line, shows a scaled
// headline glyph, then blinks a scaled sub-line. Fixed 4-cycle pixel latency.
module render_result_banner #(
  parameter int BANNER_YC    = 240,
  parameter int BANNER_H     = 160,
  parameter int GROW_STEP    = 8,
  parameter int HEAD_X       = 160,
  parameter int HEAD_Y       = 212,
  parameter int HEAD_W       = 40,
  parameter int HEAD_H       = 7,
  parameter int HEAD_SCALE   = 8,
  parameter int SUB_X        = 200,
  parameter int SUB_Y        = 285,
  parameter int SUB_W        = 80,
  parameter int SUB_H        = 7,
  parameter int SUB_SCALE    = 3,
  parameter int HOLD_FRAMES  = 30,
  parameter int BLINK_FRAMES = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  render_result_banner_if.slave bus,
  output logic [1:0]            dbg_state,
  output logic [9:0]            dbg_half_h
);

  typedef enum logic [1:0] {IDLE, GROW, HOLD, BLINK} state_t;

  localparam logic [9:0]  HALF       = 10'(BANNER_H / 2);
  localparam logic [9:0]  STEP       = 10'(GROW_STEP);
  localparam logic [10:0] YC         = 11'(BANNER_YC);
  localparam logic [15:0] HOLD_LAST  = 16'(HOLD_FRAMES - 1);
  localparam logic [15:0] BLINK_LAST = 16'(BLINK_FRAMES - 1);

  localparam logic [10:0] HX0 = 11'(HEAD_X);
  localparam logic [10:0] HX1 = 11'(HEAD_X + HEAD_W * HEAD_SCALE);
  localparam logic [10:0] HY0 = 11'(HEAD_Y);
  localparam logic [10:0] HY1 = 11'(HEAD_Y + HEAD_H * HEAD_SCALE);
  localparam logic [10:0] HSC = 11'(HEAD_SCALE);
  localparam logic [10:0] HWD = 11'(HEAD_W);
  localparam logic [10:0] SX0 = 11'(SUB_X);
  localparam logic [10:0] SX1 = 11'(SUB_X + SUB_W * SUB_SCALE);
  localparam logic [10:0] SY0 = 11'(SUB_Y);
  localparam logic [10:0] SY1 = 11'(SUB_Y + SUB_H * SUB_SCALE);
  localparam logic [10:0] SSC = 11'(SUB_SCALE);
  localparam logic [10:0] SWD = 11'(SUB_W);

  state_t      state;
  logic [9:0]  half_h;
  logic [15:0] frame_cnt;
  logic        win_q;
  logic        sub_on;

  // Frame-synchronous animation; pulses are prioritised clear > start > tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      half_h    <= '0;
      frame_cnt <= '0;
      win_q     <= 1'b0;
      sub_on    <= 1'b0;
      bus.ready <= 1'b0;
    end else if (bus.clear) begin
      state     <= IDLE;
      half_h    <= '0;
      frame_cnt <= '0;
      sub_on    <= 1'b0;
      bus.ready <= 1'b0;
    end else if (bus.start) begin
      state     <= GROW;
      win_q     <= bus.win;
      half_h    <= '0;
      frame_cnt <= '0;
      sub_on    <= 1'b0;
      bus.ready <= 1'b0;
    end else if (bus.frame_tick) begin
      case (state)
        GROW: begin
          // 11-bit sum so a step that overshoots the final height still clamps
          if ({1'b0, half_h} + {1'b0, STEP} >= {1'b0, HALF}) begin
            half_h    <= HALF;
            state     <= HOLD;
            frame_cnt <= '0;
          end else begin
            half_h <= half_h + STEP;
          end
        end
        HOLD: begin
          if (frame_cnt == HOLD_LAST) begin
            state     <= BLINK;
            frame_cnt <= '0;
            sub_on    <= 1'b1;
            bus.ready <= 1'b1;
          end else begin
            frame_cnt <= frame_cnt + 16'd1;
          end
        end
        BLINK: begin
          if (frame_cnt == BLINK_LAST) begin
            frame_cnt <= '0;
            sub_on    <= ~sub_on;
          end else begin
            frame_cnt <= frame_cnt + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign dbg_state  = state;
  assign dbg_half_h = half_h;

  // Box tests on zero-extended coordinates: an underflowed subtraction is
  // never consulted because the lower bound is compared first.
  logic [10:0] h_ext, v_ext;
  logic        in_head0, in_sub0, off0;
  logic [10:0] head_col0, head_row0, sub_col0, sub_row0;

  assign h_ext     = {1'b0, bus.h_cnt};
  assign v_ext     = {1'b0, bus.v_cnt};
  assign in_head0  = (h_ext >= HX0) && (h_ext < HX1) && (v_ext >= HY0) && (v_ext < HY1);
  assign in_sub0   = (h_ext >= SX0) && (h_ext < SX1) && (v_ext >= SY0) && (v_ext < SY1);
  assign off0      = (h_ext >= 11'd640) || (v_ext >= 11'd480);
  assign head_col0 = (h_ext - HX0) / HSC;
  assign head_row0 = (v_ext - HY0) / HSC;
  assign sub_col0  = (h_ext - SX0) / SSC;
  assign sub_row0  = (v_ext - SY0) / SSC;

  logic        in_head1, in_sub1, off1;
  logic        in_head2, in_sub2, off2;
  logic        in_head3, in_sub3, off3;
  logic [9:0]  v1, v2, v3;
  logic [10:0] head_col1, head_row1, sub_col1, sub_row1;

  always_ff @(posedge clk) begin
    if (rst) begin
      {in_head1, in_sub1, off1} <= '0;
      {in_head2, in_sub2, off2} <= '0;
      {in_head3, in_sub3, off3} <= '0;
      v1            <= '0;
      v2            <= '0;
      v3            <= '0;
      head_col1     <= '0;
      head_row1     <= '0;
      sub_col1      <= '0;
      sub_row1      <= '0;
      bus.head_addr <= '0;
      bus.sub_addr  <= '0;
    end else begin
      in_head1  <= in_head0;
      in_sub1   <= in_sub0;
      off1      <= off0;
      v1        <= bus.v_cnt;
      head_col1 <= head_col0;
      head_row1 <= head_row0;
      sub_col1  <= sub_col0;
      sub_row1  <= sub_row0;

      bus.head_addr <= in_head1 ? (head_row1 * HWD + head_col1) : '0;
      bus.sub_addr  <= in_sub1 ? (sub_row1 * SWD + sub_col1) : '0;
      in_head2      <= in_head1;
      in_sub2       <= in_sub1;
      off2          <= off1;
      v2            <= v1;

      in_head3 <= in_head2;
      in_sub3  <= in_sub2;
      off3     <= off2;
      v3       <= v2;
    end
  end

  logic        in_ban3, head_en, sub_en;
  logic [11:0] text_col, ban_col;

  assign in_ban3  = ({1'b0, v3} + {1'b0, half_h} >= YC) && ({1'b0, v3} < YC + {1'b0, half_h});
  assign head_en  = (state != IDLE);
  assign sub_en   = (state == BLINK) && sub_on;
  assign text_col = win_q ? 12'h000 : 12'hFFF;
  assign ban_col  = win_q ? 12'hF90 : 12'h000;

  // ROM bits arrive this cycle, aligned with the stage-3 flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.pixel <= 12'h000;
    end else if (off3) begin
      bus.pixel <= 12'h000;
    end else if (head_en && in_head3 && bus.head_bit && in_ban3) begin
      bus.pixel <= text_col;
    end else if (sub_en && in_sub3 && bus.sub_bit && in_ban3) begin
      bus.pixel <= text_col;
    end else if (in_ban3) begin
      bus.pixel <= ban_col;
    end else begin
      bus.pixel <= 12'hEEE;
    end
  end

endmodule

// File: tb/tb_render_result_banner.sv
// Bench for render_result_banner: glyph ROM models, a tick-count based model of
// the animation, and per-scenario tasks with inline comparisons.
module tb_render_result_banner;

  localparam int BANNER_YC = 240, BANNER_H = 160, GROW_STEP = 8;
  localparam int HEAD_X = 160, HEAD_Y = 212, HEAD_W = 40, HEAD_H = 7, HEAD_SCALE = 8;
  localparam int SUB_X = 200, SUB_Y = 285, SUB_W = 80, SUB_H = 7, SUB_SCALE = 3;
  localparam int HOLD_FRAMES = 30, BLINK_FRAMES = 20;
  localparam int HALF = BANNER_H / 2;
  localparam int GROW_TICKS = (HALF + GROW_STEP - 1) / GROW_STEP;

  logic clk = 1'b0;
  logic rst;
  logic [1:0] dbg_state;
  logic [9:0] dbg_half_h;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  render_result_banner_if bus ();

  render_result_banner dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .dbg_state  (dbg_state),
    .dbg_half_h (dbg_half_h)
  );

  logic head_rom [0:HEAD_W*HEAD_H-1];
  logic sub_rom  [0:SUB_W*SUB_H-1];

  always @(posedge clk) begin
    bus.head_bit <= (bus.head_addr < 11'(HEAD_W*HEAD_H)) ? head_rom[bus.head_addr] : 1'b0;
    bus.sub_bit  <= (bus.sub_addr < 11'(SUB_W*SUB_H)) ? sub_rom[bus.sub_addr] : 1'b0;
  end

  // Model: everything follows from how many frame ticks since the last start.
  int m_active = 0;
  int m_ticks  = 0;
  int m_win    = 0;

  function automatic int m_half();
    if (m_active == 0) return 0;
    return (m_ticks * GROW_STEP >= HALF) ? HALF : m_ticks * GROW_STEP;
  endfunction

  function automatic logic m_ready();
    return (m_active != 0) && (m_ticks >= GROW_TICKS + HOLD_FRAMES);
  endfunction

  function automatic logic m_sub_en();
    if (!m_ready()) return 1'b0;
    return (((m_ticks - GROW_TICKS - HOLD_FRAMES) / BLINK_FRAMES) % 2) == 0;
  endfunction

  function automatic logic [11:0] m_pixel(input int h, input int v);
    int half = m_half();
    logic in_ban;
    logic [11:0] txt, ban;
    if (h >= 640 || v >= 480) return 12'h000;
    in_ban = (v >= BANNER_YC - half) && (v < BANNER_YC + half);
    txt = (m_win != 0) ? 12'h000 : 12'hFFF;
    ban = (m_win != 0) ? 12'hF90 : 12'h000;
    if (m_active != 0 && in_ban &&
        h >= HEAD_X && h < HEAD_X + HEAD_W*HEAD_SCALE &&
        v >= HEAD_Y && v < HEAD_Y + HEAD_H*HEAD_SCALE &&
        head_rom[((v - HEAD_Y) / HEAD_SCALE) * HEAD_W + (h - HEAD_X) / HEAD_SCALE])
      return txt;
    if (m_sub_en() && in_ban &&
        h >= SUB_X && h < SUB_X + SUB_W*SUB_SCALE &&
        v >= SUB_Y && v < SUB_Y + SUB_H*SUB_SCALE &&
        sub_rom[((v - SUB_Y) / SUB_SCALE) * SUB_W + (h - SUB_X) / SUB_SCALE])
      return txt;
    if (in_ban) return ban;
    return 12'hEEE;
  endfunction

  // Driver tasks
  task automatic do_tick();
    @(negedge clk) bus.frame_tick = 1'b1;
    @(negedge clk) bus.frame_tick = 1'b0;
    if (m_active != 0) m_ticks++;
  endtask

  task automatic do_start(input logic w);
    @(negedge clk);
    bus.start = 1'b1;
    bus.win   = w;
    @(negedge clk) bus.start = 1'b0;
    m_active = 1;
    m_ticks  = 0;
    m_win    = int'(w);
  endtask

  // Present one coordinate, optionally check ROM addresses at t+2, pixel at t+4.
  task automatic probe(input int h, input int v, input int exp_ha, input int exp_sa, input string name);
    logic [11:0] exp;
    @(negedge clk);
    bus.h_cnt = 10'(h);
    bus.v_cnt = 10'(v);
    exp = m_pixel(h, v);
    repeat (2) @(posedge clk);
    #1;
    if (exp_ha >= 0) begin
      checks++;
      if (bus.head_addr !== 11'(exp_ha)) begin
        errors++;
        $display("FAIL %s head_addr: got %0d expected %0d", name, bus.head_addr, exp_ha);
      end
    end
    if (exp_sa >= 0) begin
      checks++;
      if (bus.sub_addr !== 11'(exp_sa)) begin
        errors++;
        $display("FAIL %s sub_addr: got %0d expected %0d", name, bus.sub_addr, exp_sa);
      end
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.pixel !== exp) begin
      errors++;
      $display("FAIL %s pixel (h=%0d v=%0d): got %h expected %h", name, h, v, bus.pixel, exp);
    end
  endtask

  task automatic check_ctl(input string name);
    checks++;
    if (dbg_half_h !== 10'(m_half()) || bus.ready !== m_ready()) begin
      errors++;
      $display("FAIL %s: half_h=%0d ready=%b expected half_h=%0d ready=%b",
               name, dbg_half_h, bus.ready, m_half(), m_ready());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.h_cnt = 10'd700;
    bus.v_cnt = 10'd100;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.pixel !== 12'h000 || bus.ready !== 1'b0 || dbg_half_h !== 10'd0) begin
      errors++;
      $display("FAIL reset_values: pixel=%h ready=%b half_h=%0d expected 000 0 0",
               bus.pixel, bus.ready, dbg_half_h);
    end
    rst = 1'b0;
    m_active = 0;
    repeat (5) @(negedge clk);
    bus.h_cnt = 10'd100;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.pixel !== 12'h000) begin
      errors++;
      $display("FAIL latency_t3: got %h expected 000", bus.pixel);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.pixel !== 12'hEEE) begin
      errors++;
      $display("FAIL latency_t4: got %h expected eee", bus.pixel);
    end
    do_tick();
    do_tick();
    check_ctl("idle_ticks");
    probe(0, 0, 0, 0, "idle_origin");
    probe(639, 479, -1, -1, "idle_corner");
    probe(320, 240, -1, -1, "idle_centre");
    probe(700, 100, -1, -1, "offscreen_h");
    probe(100, 480, -1, -1, "offscreen_v");
  endtask

  task automatic test_grow();
    do_start(1'b1);
    check_ctl("grow_start");
    for (int k = 1; k <= GROW_TICKS; k++) begin
      do_tick();
      check_ctl($sformatf("grow_tick%0d", k));
      if (k == 3 || k == 4) begin
        probe(100, 215, -1, -1, $sformatf("grow%0d_line215", k));
        probe(100, 216, -1, -1, $sformatf("grow%0d_line216", k));
        probe(100, 200, -1, -1, $sformatf("grow%0d_line200", k));
      end
    end
  endtask

  task automatic test_hold();
    check_ctl("hold_entry");
    probe(160, 212, 0, -1, "hold_head_origin");
    probe(175, 229, 81, -1, "hold_head_cell81");
    probe(479, 267, 279, -1, "hold_head_last");
    probe(480, 212, 0, -1, "hold_head_right_edge");
    probe(159, 212, 0, -1, "hold_head_left_edge");
    probe(160, 211, 0, -1, "hold_head_top_edge");
    probe(200, 285, -1, 0, "hold_sub_hidden");
    probe(100, 161, -1, -1, "hold_banner_top");
    probe(100, 320, -1, -1, "hold_below_banner");
  endtask

  task automatic test_blink();
    for (int k = 1; k <= HOLD_FRAMES; k++) begin
      do_tick();
      check_ctl($sformatf("hold_tick%0d", k));
    end
    probe(202, 291, -1, 160, "blink_sub_cell160");
    probe(439, 305, -1, 559, "blink_sub_last");
    probe(440, 285, -1, 0, "blink_sub_right_edge");
    for (int k = 0; k < 3 * BLINK_FRAMES; k++) begin
      probe(200, 285, -1, -1, $sformatf("blink_phase%0d", k));
      do_tick();
    end
    check_ctl("blink_ready");
  endtask

  task automatic test_back_to_back(input int n, input string name);
    logic [11:0] exp_q[$];
    logic [11:0] exp;
    int h, v;
    for (int i = 0; i < n + 4; i++) begin
      @(negedge clk);
      if (i >= 4) begin
        exp = exp_q.pop_front();
        checks++;
        if (bus.pixel !== exp) begin
          errors++;
          $display("FAIL %s stream%0d: got %h expected %h", name, i - 4, bus.pixel, exp);
        end
      end
      if (i < n) begin
        case ($urandom_range(0, 3))
          0: begin h = $urandom_range(0, 799); v = $urandom_range(0, 520); end
          1: begin h = $urandom_range(150, 490); v = $urandom_range(205, 275); end
          2: begin h = $urandom_range(195, 445); v = $urandom_range(280, 310); end
          default: begin h = $urandom_range(0, 700); v = $urandom_range(150, 330); end
        endcase
        bus.h_cnt = 10'(h);
        bus.v_cnt = 10'(v);
        exp_q.push_back(m_pixel(h, v));
      end
    end
  endtask

  task automatic test_restart_lose();
    do_start(1'b1);
    repeat (5) do_tick();
    check_ctl("pre_restart");
    do_start(1'b0);
    check_ctl("restart_half0");
    probe(100, 240, -1, -1, "restart_no_banner");
    repeat (4) do_tick();
    check_ctl("lose_grow4");
    probe(100, 240, -1, -1, "lose_banner");
    probe(160, 212, -1, -1, "lose_text");
    test_back_to_back(200, "lose_grow");
  endtask

  task automatic test_clear_start();
    repeat (2) do_tick();
    @(negedge clk);
    bus.clear = 1'b1;
    bus.start = 1'b1;
    bus.win   = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    bus.start = 1'b0;
    m_active = 0;
    check_ctl("clear_start");
    repeat (2) do_tick();
    check_ctl("clear_idle_ticks");
    probe(100, 240, -1, -1, "clear_background");
  endtask

  task automatic test_rst_blink();
    do_start(1'b1);
    repeat (GROW_TICKS + HOLD_FRAMES) do_tick();
    check_ctl("blink_before_rst");
    test_back_to_back(200, "blink_stream");
    @(negedge clk);
    rst = 1'b1;
    bus.h_cnt = 10'd700;
    @(negedge clk) rst = 1'b0;
    m_active = 0;
    check_ctl("rst_in_blink");
    checks++;
    if (bus.pixel !== 12'h000) begin
      errors++;
      $display("FAIL rst_pixel: got %h expected 000", bus.pixel);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (bus.pixel !== 12'h000) begin
      errors++;
      $display("FAIL rst_flush: got %h expected 000", bus.pixel);
    end
    probe(320, 240, -1, -1, "rst_background");
  endtask

  initial begin
    rst = 1'b1;
    bus.h_cnt = '0;
    bus.v_cnt = '0;
    bus.frame_tick = 1'b0;
    bus.start = 1'b0;
    bus.win = 1'b0;
    bus.clear = 1'b0;
    for (int i = 0; i < HEAD_W*HEAD_H; i++) head_rom[i] = 1'($urandom_range(0, 1));
    for (int i = 0; i < SUB_W*SUB_H; i++) sub_rom[i] = 1'($urandom_range(0, 1));
    head_rom[0]   = 1'b1;
    head_rom[81]  = 1'b1;
    head_rom[279] = 1'b1;
    sub_rom[0]    = 1'b1;

    test_reset();
    test_grow();
    test_hold();
    test_blink();
    test_back_to_back(300, "blink_mixed");
    test_restart_lose();
    test_clear_start();
    test_rst_blink();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
